// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the padded 3D FFT output stream.
package fft_stream_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FFT_N  = 8;

  // Index bits for a {z,y,x} position in an FFT_N^3 cube.
  function automatic int unsigned idx_width(input int unsigned n);
    return 3 * $clog2(n);
  endfunction

  localparam int unsigned IDX_W     = idx_width(FFT_N);
  localparam int unsigned FRAME_LEN = FFT_N * FFT_N * FFT_N;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t lane0;
    cplx_t lane1;
  } pair_t;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/fft_pair_fifo.sv
// Synchronous FIFO of sample pairs; full/empty come from wrap-bit pointers.
// Exposes the head and the entry behind it so the reader can pop without a bubble.
module fft_pair_fifo
  import fft_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  pair_t                  data_i,
  input  logic                   pop_i,
  output pair_t                  head_c_o,
  output pair_t                  next_c_o,
  output logic                   full_c_o,
  output logic                   empty_c_o,
  output logic [$clog2(DEPTH):0] cnt_c_o,
  output logic [$clog2(DEPTH):0] free_nxt_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt_addr;
  logic          do_push;
  logic          do_pop;
  pair_t         mem_q [DEPTH];

  always_comb begin
    full_c_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_c_o    = (wr_ptr_q == rd_ptr_q);
    do_push      = push_i && !full_c_o;
    do_pop       = pop_i && !empty_c_o;
    wr_ptr_d     = wr_ptr_q + PW'(do_push);
    rd_ptr_d     = rd_ptr_q + PW'(do_pop);
    cnt_c_o      = wr_ptr_q - rd_ptr_q;
    // Free entries after this cycle's push/pop land.
    free_nxt_c_o = PW'(DEPTH) - (wr_ptr_d - rd_ptr_d);
    rd_nxt_addr  = rd_ptr_q[AW-1:0] + AW'(1);
    head_c_o     = mem_q[rd_ptr_q[AW-1:0]];
    next_c_o     = mem_q[rd_nxt_addr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Buffers two-lane FFT output pairs and serialises them to one indexed sample per cycle.
// Optional FFT_OUT_SERIALIZER_DROP_CNT_EN adds a saturating dropped-pair counter (io_drop_cnt).
module fft_out_serializer
  import fft_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SKID  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  input  logic [DATA_W-1:0] io_in_data_0_Re,
  input  logic [DATA_W-1:0] io_in_data_0_Im,
  input  logic [DATA_W-1:0] io_in_data_1_Re,
  input  logic [DATA_W-1:0] io_in_data_1_Im,
  output logic              io_in_en,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data_Re,
  output logic [DATA_W-1:0] io_out_data_Im,
  output logic [IDX_W-1:0]  io_out_idx,
  output logic              io_out_last,
  output logic              io_overflow
`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
  ,
  output logic [15:0]       io_drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pair_t          wr_pair;
  pair_t          head;
  pair_t          next;
  logic           full;
  logic           empty;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  free_nxt;
  logic           xfer;
  logic           pop;
  logic           drop;

  lane_e          state_q, state_d;
  logic           valid_q, valid_d;
  cplx_t          data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           last_q, last_d;
  logic           en_q, en_d;
  logic           ovf_q, ovf_d;

  assign wr_pair = '{lane0: '{re: io_in_data_0_Re, im: io_in_data_0_Im},
                     lane1: '{re: io_in_data_1_Re, im: io_in_data_1_Im}};

  fft_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clock),
    .rst_i        (reset),
    .push_i       (io_in_valid),
    .data_i       (wr_pair),
    .pop_i        (pop),
    .head_c_o     (head),
    .next_c_o     (next),
    .full_c_o     (full),
    .empty_c_o    (empty),
    .cnt_c_o      (cnt),
    .free_nxt_c_o (free_nxt)
  );

  // Lane FSM plus output register load; the index is a plain {z,y,x} binary counter,
  // so x->y->z carries and the frame wrap fall out of FFT_N being a power of two.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    xfer    = valid_q && io_out_ready;
    pop     = xfer && (state_q == LANE1);
    drop    = io_in_valid && full;

    if (xfer) begin
      state_d = (state_q == LANE0) ? LANE1 : LANE0;
      idx_d   = idx_q + IDX_W'(1);
    end

    if (!valid_q || xfer) begin
      if (state_d == LANE1) begin
        data_d  = head.lane1;
        valid_d = 1'b1;
      end else if (pop && (cnt >= CW'(2))) begin
        data_d  = next.lane0;
        valid_d = 1'b1;
      end else if (!pop && !empty) begin
        data_d  = head.lane0;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    last_d = (idx_d == IDX_W'(FRAME_LEN - 1));
    en_d   = (free_nxt > CW'(SKID));
    ovf_d  = ovf_q || drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LANE0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign io_drop_cnt = drop_q;
`endif

  assign io_in_en       = en_q;
  assign io_out_valid   = valid_q;
  assign io_out_data_Re = data_q.re;
  assign io_out_data_Im = data_q.im;
  assign io_out_idx     = idx_q;
  assign io_out_last    = last_q;
  assign io_overflow    = ovf_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: reset, latency, backpressure, throttle, overflow, frame index, mid-frame reset.
module tb_fft_out_serializer;

  localparam int DEPTH = 16;
  localparam int SKID  = 2;
  localparam int FRAME = 512;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic [31:0] io_in_data_0_Re, io_in_data_0_Im, io_in_data_1_Re, io_in_data_1_Im;
  logic        io_in_en;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_data_Re, io_out_data_Im;
  logic [8:0]  io_out_idx;
  logic        io_out_last;
  logic        io_overflow;
`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
  logic [15:0] io_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int core_next, core_left, core_skid;

  fft_out_serializer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_data_0_Re (io_in_data_0_Re),
    .io_in_data_0_Im (io_in_data_0_Im),
    .io_in_data_1_Re (io_in_data_1_Re),
    .io_in_data_1_Im (io_in_data_1_Im),
    .io_in_en        (io_in_en),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_data_Re  (io_out_data_Re),
    .io_out_data_Im  (io_out_data_Im),
    .io_out_idx      (io_out_idx),
    .io_out_last     (io_out_last),
    .io_overflow     (io_overflow)
`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
    ,
    .io_drop_cnt     (io_drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Pair k carries samples 2k and 2k+1: Re = sample number, Im = 0xA0000000 | sample.
  task automatic drive_pair(input int k);
    io_in_valid     = 1'b1;
    io_in_data_0_Re = 32'(2 * k);
    io_in_data_0_Im = 32'hA000_0000 | 32'(2 * k);
    io_in_data_1_Re = 32'(2 * k + 1);
    io_in_data_1_Im = 32'hA000_0000 | 32'(2 * k + 1);
  endtask

  task automatic do_reset;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Core model: produces while enabled, then SKID more pairs after enable drops.
  task automatic core_drive;
    if (core_left > 0 && (io_in_en || core_skid > 0)) begin
      if (!io_in_en) core_skid--;
      drive_pair(core_next);
      core_next++;
      core_left--;
    end else begin
      io_in_valid = 1'b0;
    end
    if (io_in_en) core_skid = SKID;
  endtask

  task automatic test_reset;
    io_in_data_0_Re = '0; io_in_data_0_Im = '0;
    io_in_data_1_Re = '0; io_in_data_1_Im = '0;
    do_reset;
    checks++;
    if (io_out_valid !== 1'b0 || io_out_last !== 1'b0 || io_overflow !== 1'b0 || io_in_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b last=%b ovf=%b en=%b, required all 0",
               io_out_valid, io_out_last, io_overflow, io_in_en);
    end
    checks++;
    if (io_out_idx !== 9'd0 || io_out_data_Re !== 32'd0 || io_out_data_Im !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: idx=%0d re=%h im=%h, required 0", io_out_idx, io_out_data_Re, io_out_data_Im);
    end
`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
    checks++;
    if (io_drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d required 0", io_drop_cnt);
    end
`endif
    tick;
    checks++;
    if (io_in_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_en_rise: got %b required 1", io_in_en);
    end
  endtask

  task automatic test_single_pair;
    do_reset;
    io_out_ready    = 1'b1;
    io_in_valid     = 1'b1;
    io_in_data_0_Re = 32'h3F80_0000;
    io_in_data_0_Im = 32'h0000_0000;
    io_in_data_1_Re = 32'h4000_0000;
    io_in_data_1_Im = 32'h4040_0000;
    tick;
    io_in_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_t0_valid: got %b required 0", io_out_valid);
    end
    tick;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_data_Re !== 32'h3F80_0000 || io_out_data_Im !== 32'h0
        || io_out_idx !== 9'd0 || io_out_last !== 1'b0) begin
      errors++;
      $display("FAIL single_lane0: valid=%b re=%h im=%h idx=%0d, required 1 3f800000 00000000 0",
               io_out_valid, io_out_data_Re, io_out_data_Im, io_out_idx);
    end
    tick;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_data_Re !== 32'h4000_0000 || io_out_data_Im !== 32'h4040_0000
        || io_out_idx !== 9'd1) begin
      errors++;
      $display("FAIL single_lane1: valid=%b re=%h im=%h idx=%0d, required 1 40000000 40400000 1",
               io_out_valid, io_out_data_Re, io_out_data_Im, io_out_idx);
    end
    tick;
    checks++;
    if (io_out_valid !== 1'b0 || io_out_idx !== 9'd2 || io_in_en !== 1'b1) begin
      errors++;
      $display("FAIL single_drained: valid=%b idx=%0d en=%b, required 0 2 1", io_out_valid, io_out_idx, io_in_en);
    end
  endtask

  task automatic test_backpressure;
    int exp_s;
    do_reset;
    drive_pair(0);
    tick;
    drive_pair(1);
    tick;
    io_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (io_out_valid !== 1'b1 || io_out_data_Re !== 32'd0 || io_out_data_Im !== 32'hA000_0000
          || io_out_idx !== 9'd0 || io_out_last !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b re=%h im=%h idx=%0d, required 1 0 a0000000 0",
                 c, io_out_valid, io_out_data_Re, io_out_data_Im, io_out_idx);
      end
      tick;
    end
    io_out_ready = 1'b1;
    exp_s = 0;
    for (int c = 0; c < 20; c++) begin
      if (io_out_valid) begin
        checks++;
        if (io_out_data_Re !== 32'(exp_s) || io_out_idx !== 9'(exp_s)) begin
          errors++;
          $display("FAIL backpressure_order: re=%0d idx=%0d, required %0d", io_out_data_Re, io_out_idx, exp_s);
        end
        exp_s++;
      end
      tick;
    end
    checks++;
    if (exp_s != 4) begin
      errors++;
      $display("FAIL backpressure_count: got %0d samples, required 4", exp_s);
    end
  endtask

  task automatic test_throttle;
    int exp_s, occ, bubbles, lane;
    bit en_low_seen, push, pop;
    exp_s = 0; occ = 0; bubbles = 0; lane = 0; en_low_seen = 0;
    do_reset;
    io_out_ready = 1'b1;
    core_next = 0; core_left = 60; core_skid = 0;
    for (int cyc = 0; cyc < 400 && exp_s < 120; cyc++) begin
      pop = 0;
      if (io_out_valid) begin
        checks++;
        if (io_out_data_Re !== 32'(exp_s)) begin
          errors++;
          $display("FAIL throttle_data: re=%0d required %0d", io_out_data_Re, exp_s);
        end
        if (lane == 1) pop = 1;
        lane ^= 1;
        exp_s++;
      end else if (exp_s > 0 && exp_s < 110) begin
        bubbles++;
      end
      core_drive;
      push = io_in_valid && (occ < DEPTH);
      tick;
      occ = occ + int'(push) - int'(pop);
      checks++;
      if (io_in_en !== ((DEPTH - occ) > SKID)) begin
        errors++;
        $display("FAIL throttle_en: en=%b with occupancy %0d, required %b", io_in_en, occ, ((DEPTH - occ) > SKID));
      end
      if (!io_in_en) en_low_seen = 1;
    end
    io_in_valid = 1'b0;
    checks++;
    if (exp_s != 120 || bubbles != 0 || !en_low_seen || io_overflow !== 1'b0) begin
      errors++;
      $display("FAIL throttle_summary: samples=%0d bubbles=%0d en_low=%0d ovf=%b, required 120 0 1 0",
               exp_s, bubbles, en_low_seen, io_overflow);
    end
  endtask

  task automatic test_overflow;
    int exp_s;
    do_reset;
    for (int k = 0; k < DEPTH + 3; k++) begin
      drive_pair(k);
      tick;
      if (k == DEPTH - 1) begin
        checks++;
        if (io_overflow !== 1'b0) begin
          errors++;
          $display("FAIL overflow_at_full: got %b required 0", io_overflow);
        end
      end
      if (k == DEPTH) begin
        checks++;
        if (io_overflow !== 1'b1) begin
          errors++;
          $display("FAIL overflow_set: got %b required 1", io_overflow);
        end
      end
    end
    io_in_valid = 1'b0;
    tick;
`ifdef FFT_OUT_SERIALIZER_DROP_CNT_EN
    checks++;
    if (io_drop_cnt !== 16'd3) begin
      errors++;
      $display("FAIL overflow_drop_cnt: got %0d required 3", io_drop_cnt);
    end
`endif
    io_out_ready = 1'b1;
    exp_s = 0;
    for (int c = 0; c < 100; c++) begin
      if (io_out_valid) begin
        checks++;
        if (io_out_data_Re !== 32'(exp_s)) begin
          errors++;
          $display("FAIL overflow_drain: re=%0d required %0d", io_out_data_Re, exp_s);
        end
        exp_s++;
      end
      tick;
    end
    checks++;
    if (exp_s != 2 * DEPTH || io_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_contents: samples=%0d ovf=%b, required %0d 1", exp_s, io_overflow, 2 * DEPTH);
    end
  endtask

  task automatic test_frame;
    int exp_s, pos;
    exp_s = 0;
    do_reset;
    io_out_ready = 1'b1;
    core_next = 0; core_left = 300; core_skid = 0;
    for (int cyc = 0; cyc < 2000 && exp_s < 600; cyc++) begin
      if (io_out_valid) begin
        pos = exp_s % FRAME;
        checks++;
        if (io_out_data_Re !== 32'(exp_s) || io_out_idx !== 9'(pos) || io_out_last !== (pos == FRAME - 1)) begin
          errors++;
          $display("FAIL frame_sample %0d: re=%0d idx=%0d last=%b, required re=%0d idx=%0d last=%b",
                   exp_s, io_out_data_Re, io_out_idx, io_out_last, exp_s, pos, (pos == FRAME - 1));
        end
        if (exp_s == 8) begin
          checks++;
          if (io_out_idx !== 9'b000_001_000) begin
            errors++;
            $display("FAIL frame_x_carry: idx=%b required 000001000", io_out_idx);
          end
        end
        if (exp_s == 64) begin
          checks++;
          if (io_out_idx !== 9'b001_000_000) begin
            errors++;
            $display("FAIL frame_y_carry: idx=%b required 001000000", io_out_idx);
          end
        end
        if (exp_s == 511) begin
          checks++;
          if (io_out_idx !== 9'b111_111_111 || io_out_last !== 1'b1) begin
            errors++;
            $display("FAIL frame_last: idx=%0d last=%b, required 511 1", io_out_idx, io_out_last);
          end
        end
        if (exp_s == 512) begin
          checks++;
          if (io_out_idx !== 9'd0 || io_out_last !== 1'b0) begin
            errors++;
            $display("FAIL frame_wrap: idx=%0d last=%b, required 0 0", io_out_idx, io_out_last);
          end
        end
        exp_s++;
      end
      core_drive;
      tick;
    end
    io_in_valid = 1'b0;
    checks++;
    if (exp_s != 600 || io_overflow !== 1'b0) begin
      errors++;
      $display("FAIL frame_count: samples=%0d ovf=%b, required 600 0", exp_s, io_overflow);
    end
  endtask

  task automatic test_reset_mid;
    int exp_s;
    exp_s = 0;
    do_reset;
    io_out_ready = 1'b1;
    core_next = 0; core_left = 200; core_skid = 0;
    for (int cyc = 0; cyc < 500 && exp_s < 100; cyc++) begin
      if (io_out_valid) exp_s++;
      core_drive;
      tick;
    end
    checks++;
    if (exp_s != 100) begin
      errors++;
      $display("FAIL reset_mid_reach: samples=%0d required 100", exp_s);
    end
    reset       = 1'b1;
    io_in_valid = 1'b0;
    tick;
    reset = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0 || io_out_idx !== 9'd0 || io_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cleared: valid=%b idx=%0d last=%b, required 0 0 0", io_out_valid, io_out_idx, io_out_last);
    end
    io_in_valid     = 1'b1;
    io_in_data_0_Re = 32'h1234_5678;
    io_in_data_0_Im = 32'h9ABC_DEF0;
    io_in_data_1_Re = 32'h0BAD_F00D;
    io_in_data_1_Im = 32'hCAFE_BABE;
    tick;
    io_in_valid = 1'b0;
    tick;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_data_Re !== 32'h1234_5678 || io_out_data_Im !== 32'h9ABC_DEF0
        || io_out_idx !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_lane0: valid=%b re=%h im=%h idx=%0d, required 1 12345678 9abcdef0 0",
               io_out_valid, io_out_data_Re, io_out_data_Im, io_out_idx);
    end
    tick;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_data_Re !== 32'h0BAD_F00D || io_out_idx !== 9'd1) begin
      errors++;
      $display("FAIL reset_mid_lane1: valid=%b re=%h idx=%0d, required 1 0badf00d 1",
               io_out_valid, io_out_data_Re, io_out_idx);
    end
    tick;
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flushed: valid=%b required 0", io_out_valid);
    end
  endtask

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    test_reset;
    test_single_pair;
    test_backpressure;
    test_throttle;
    test_overflow;
    test_frame;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
